// File: rtl/cu_sequencer.sv
// Microprogrammed control sequencer: fetch, decode, then an opcode-selected execute
// sequence, each micro-step holding control_signals for two cycles. Optional SHR via CU_SHR_EN.
module cu_sequencer #(
  parameter int STEP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  opcode,
  input  logic        acc_neg,
  output logic [15:0] control_signals,
  output logic        halted,
  output logic        instr_done,
  output logic [3:0]  dbg_state
);

  // step_q names the step that the next load edge will put on the bus.
  // S_SEL is a selector step, mapped to the real execute step from opcode/acc_neg at that load edge.
  typedef enum logic [3:0] {
    S_F0, S_F1, S_F2, S_DEC, S_SEL, S_RD, S_BR, S_ST0, S_FIN, S_HALT
  } step_t;

  localparam logic LAST_PHASE = 1'(STEP_CYCLES - 1);

  step_t       step_q;
  step_t       cur;
  step_t       succ;
  logic        phase_q;
  logic        started_q;
  logic        load;
  logic [15:0] fin_q;
  logic [15:0] fin_d;
  logic [15:0] bus_d;

  assign load = (phase_q == 1'b0);

  always_comb begin
    cur   = step_q;
    fin_d = fin_q;
    if (step_q == S_SEL) begin
      case (opcode)
        8'h01: begin cur = S_ST0; fin_d = 16'h0400; end
        8'h02: begin cur = S_RD;  fin_d = 16'h0800; end
        8'h03: begin cur = S_RD;  fin_d = 16'h0040; end
        8'h04: begin cur = S_RD;  fin_d = 16'h0080; end
        8'h05: begin cur = S_FIN; fin_d = acc_neg ? 16'h0000 : 16'h0200; end
        8'h06: begin cur = S_FIN; fin_d = 16'h0200; end
        8'h07: cur = S_HALT;
        8'h08: begin cur = S_RD;  fin_d = 16'h2000; end
`ifdef CU_SHR_EN
        8'h09: begin cur = S_FIN; fin_d = 16'h4000; end
`endif
        default: cur = S_F0;
      endcase
    end
  end

  always_comb begin
    bus_d = 16'h0000;
    succ  = S_F0;
    case (cur)
      S_F0:    begin bus_d = 16'h0001; succ = S_F1;  end
      S_F1:    begin bus_d = 16'h0012; succ = S_F2;  end
      S_F2:    begin bus_d = 16'h0004; succ = S_DEC; end
      S_DEC:   begin bus_d = 16'h0008; succ = S_SEL; end
      S_RD:    begin bus_d = 16'h0002; succ = S_BR;  end
      S_BR:    begin bus_d = 16'h0020; succ = S_FIN; end
      S_ST0:   begin bus_d = 16'h0100; succ = S_FIN; end
      S_FIN:   begin bus_d = fin_d;    succ = S_F0;  end
      S_HALT:  begin bus_d = 16'h8000; succ = S_HALT; end
      default: begin bus_d = 16'h0000; succ = S_F0;  end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q          <= S_F0;
      phase_q         <= 1'b0;
      started_q       <= 1'b0;
      fin_q           <= 16'h0000;
      control_signals <= 16'h0000;
    end else begin
      phase_q <= (phase_q == LAST_PHASE) ? 1'b0 : phase_q + 1'b1;
      if (load) begin
        step_q          <= succ;
        control_signals <= bus_d;
        fin_q           <= fin_d;
        started_q       <= 1'b1;
      end
    end
  end

  // Second cycle of a step whose successor is FETCH0 closes the instruction.
  assign instr_done = started_q && load && (cur == S_F0);
  assign halted     = (step_q == S_HALT);
  assign dbg_state  = step_q;

endmodule

// File: doc/cu_sequencer.md
# cu_sequencer

Microprogrammed control sequencer for the 8-bit accumulator CPU. It drives the shared 16-bit `control_signals` bus consumed by PC, MAR, MBR, IR, BR, ACC/ALU and memory. Each instruction runs as a fixed sequence of micro-steps: fetch, decode, then an opcode-dependent execute sequence. Every micro-step holds the bus constant for exactly two clock cycles, which is the contract that downstream registers (notably PC's increment) depend on.

## Interface
Parameters:
- `STEP_CYCLES`, 2: clock cycles per micro-step. Only the value 2 is supported; the bus contract depends on it.

Ports:
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `opcode` input 8: IR[15:8]. Valid from the end of step FETCH2 until the next FETCH2.
- `acc_neg` input 1: ACC sign flag (ACC[15]).
- `control_signals` output 16: registered micro-operation bus.
- `halted` output 1: high while in HALT.
- `instr_done` output 1: one-cycle pulse on the final cycle of each instruction.

## Operation
Control bit map:
- c0 pc_to_mar, c1 mem_rd, c2 mbr_to_ir, c3 ir_to_mar.
- c4 pc_inc, c5 mbr_to_br, c6 alu_add, c7 alu_sub.
- c8 acc_to_mbr, c9 mbr_to_pc, c10 mem_wr, c11 br_to_acc.
- c12 acc_clear, c13 alu_and, c14 acc_shr, c15 halt.

Common steps for every instruction, with the bus value driven in each:
- FETCH0: 0x0001.
- FETCH1: 0x0012 (mem_rd | pc_inc).
- FETCH2: 0x0004.
- DECODE: 0x0008.

`opcode` is sampled on the last cycle of DECODE and selects the execute sequence:
- 0x01 STORE: 0x0100, then 0x0400.
- 0x02 LOAD: 0x0002, 0x0020, 0x0800.
- 0x03 ADD: 0x0002, 0x0020, 0x0040.
- 0x04 SUB: 0x0002, 0x0020, 0x0080.
- 0x05 JMPGEZ: 0x0200 if `acc_neg`=0, otherwise 0x0000. `acc_neg` is sampled with the opcode.
- 0x06 JMP: 0x0200.
- 0x07 HALT: enter HALT and drive 0x8000.
- 0x08 AND: 0x0002, 0x0020, 0x2000.
- Any other opcode: NOP. There is no execute step; the next step is FETCH0.

Sequencing rules:
- After the last execute step the sequencer returns to FETCH0.
- HALT is absorbing. The bus stays 0x8000 and `halted`=1 until `rst_n` is asserted. `opcode` is ignored in HALT.
- Exactly one micro-step is active at a time. No two steps overlap or merge.

## Timing
Reset values:
- `control_signals`=0x0000, `halted`=0, `instr_done`=0.
- Internal state: FETCH0, phase 0.

Step timing:
- The first rising edge after `rst_n` deasserts loads 0x0001. It is held for that cycle and the next.
- Every step is exactly 2 cycles. The bus changes only on phase-0 edges.
- pc_inc is therefore high for exactly 2 consecutive cycles per instruction, aligned to a step boundary.

Instruction lengths (steps / cycles):
- NOP: 4 / 8.
- JMP, JMPGEZ: 5 / 10.
- STORE: 6 / 12.
- LOAD, ADD, SUB, AND: 7 / 14.

`instr_done`:
- High on the second cycle of the last step of an instruction.
- Not asserted for HALT.
- Not asserted during the reset cycle.

Reset and input changes:
- Reset mid-step forces the bus to 0x0000 immediately (asynchronous). Restart is as above.
- `opcode` or `acc_neg` changes outside the sampling cycle have no effect.

## Configuration
- `CU_SHR_EN` defined: opcode 0x09 SHR executes a single step 0x4000, giving 5 steps / 10 cycles.
- Not defined: 0x09 decodes as NOP, and bit c14 is constant 0.

## Test plan
- Reset release with `opcode`=0x00: bus sequence 0x0001×2, 0x0012×2, 0x0004×2, 0x0008×2, then 0x0001. `instr_done` pulses at cycle 8.
- `opcode`=0x02: after DECODE, bus 0x0002×2, 0x0020×2, 0x0800×2. `instr_done` at cycle 14. pc_inc is high in exactly cycles 3–4.
- `opcode`=0x05 with `acc_neg`=0 gives 0x0200×2. Repeat with `acc_neg`=1: 0x0000×2. Toggling `acc_neg` during the execute step changes nothing.
- `opcode`=0x07: bus goes to 0x8000 and `halted`=1, held for 100 cycles while `opcode` is changed randomly. Asserting `rst_n` low gives 0x0000 and `halted`=0.
- Assert `rst_n` low mid-FETCH1 (bus 0x0012): output is 0x0000 asynchronously. After release the next step is FETCH0 (0x0001).
- `opcode`=0x09: with `CU_SHR_EN`, bus 0x4000×2 then 0x0001. Without it, 0x0001 directly after DECODE.
